// File: rtl/wam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wam_pkg
// Brief    : Shared channel-state encoding and default timing constants.
// Revision : 1.0  initial release
// ============================================================================
package wam_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HELD = 2'd2,
        REL  = 2'd3
    } ch_state_e;

    localparam int DEB_TICKS_DEF = 500000;
    localparam int CNT_W_DEF     = 20;
    localparam int RPT_DLY_DEF   = 25000000;
    localparam int RPT_PER_DEF   = 10000000;

    // A channel is "counting" while it waits to confirm a new level.
    function automatic logic is_counting(input ch_state_e s);
        return (s == ARM) || (s == REL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wam_deb_ch.sv
`default_nettype none
// ============================================================================
// Module   : wam_deb_ch
// Brief    : One debounce channel: 2-flop synchronizer, 4-state FSM, counter,
//            press pulse and optional hold-to-repeat pulse train.
// Revision : 1.0  initial release
// ============================================================================
module wam_deb_ch
    import wam_pkg::*;
#(
    parameter int DEB_TICKS = DEB_TICKS_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int RPT_DLY   = RPT_DLY_DEF,
    parameter int RPT_PER   = RPT_PER_DEF,
    parameter bit RPT_EN    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_pulse,
    output logic o_level,
    output logic o_busy
);

    localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEB_TICKS - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    logic [1:0]       sync_q, sync_d;
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             level_q, level_d;
    logic             in_s;
    logic             press;
    logic             rpt_hit;
    logic [CNT_W-1:0] cnt_inc;

    assign in_s    = sync_q[1];
    assign cnt_inc = (cnt_q == c_CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        sync_d  = {sync_q[0], i_raw};
        state_d = state_q;
        cnt_d   = cnt_q;
        press   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_s) begin
                    state_d = ARM;
                    cnt_d   = '0;
                end
            end
            ARM: begin
                if (!in_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == c_DEB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    press   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                if (!in_s) begin
                    state_d = REL;
                    cnt_d   = '0;
                end
            end
            REL: begin
                // A bounce back to 1 restores HELD without a new press.
                if (in_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == c_DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        pulse_d = press | rpt_hit;
        level_d = (state_d == HELD) || (state_d == REL);
    end

    generate
        if (RPT_EN) begin : g_rpt
            localparam int c_RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
            localparam int c_RPT_W   = $clog2(c_RPT_MAX + 1);
            localparam logic [c_RPT_W-1:0] c_DLY_LAST = c_RPT_W'(RPT_DLY - 1);
            localparam logic [c_RPT_W-1:0] c_PER_LAST = c_RPT_W'(RPT_PER - 1);

            logic [c_RPT_W-1:0] rpt_q, rpt_d;
            logic               again_q, again_d;
            logic               hit;

            // Counter restarts on every HELD entry; first interval is the
            // initial delay, later intervals use the repeat period.
            always_comb begin
                rpt_d   = rpt_q;
                again_d = again_q;
                hit     = 1'b0;
                if ((state_q == HELD) && (state_d == HELD)) begin
                    if (rpt_q == (again_q ? c_PER_LAST : c_DLY_LAST)) begin
                        hit     = 1'b1;
                        rpt_d   = '0;
                        again_d = 1'b1;
                    end else if (rpt_q != '1) begin
                        rpt_d = rpt_q + 1'b1;
                    end
                end else begin
                    rpt_d   = '0;
                    again_d = 1'b0;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rpt_q   <= '0;
                    again_q <= 1'b0;
                end else begin
                    rpt_q   <= rpt_d;
                    again_q <= again_d;
                end
            end

            assign rpt_hit = hit;
        end else begin : g_no_rpt
            assign rpt_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    assign o_pulse = pulse_q;
    assign o_level = level_q;
    assign o_busy  = is_counting(state_q);

endmodule
`default_nettype wire

// File: rtl/wam_deb.sv
`default_nettype none
// ============================================================================
// Module   : wam_deb
// Brief    : Debouncer for 3 game buttons and 8 tap switches. Define
//            WAM_AUTOREPEAT_EN to add hold-to-repeat on the lft/rgt buttons.
// Revision : 1.0  initial release
// ============================================================================
module wam_deb
    import wam_pkg::*;
#(
    parameter int DEB_TICKS = DEB_TICKS_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int RPT_DLY   = RPT_DLY_DEF,
    parameter int RPT_PER   = RPT_PER_DEF
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_lft,
    input  logic       btn_rgt,
    input  logic       btn_pse,
    input  logic [7:0] sw_raw,
    output logic       lft,
    output logic       rgt,
    output logic       pse,
    output logic [7:0] sw,
    output logic       busy
);

    localparam int c_NCH = 11;
    localparam int c_LFT = 8;
    localparam int c_RGT = 9;
    localparam int c_PSE = 10;

`ifdef WAM_AUTOREPEAT_EN
    localparam bit c_RPT_EN = 1'b1;
`else
    localparam bit c_RPT_EN = 1'b0;
`endif

    logic [c_NCH-1:0] raw_in;
    logic [c_NCH-1:0] ch_pulse;
    logic [c_NCH-1:0] ch_level;
    logic [c_NCH-1:0] ch_busy;
    logic             busy_q, busy_d;
    logic             unused_ch;

    assign raw_in = {btn_pse, btn_rgt, btn_lft, sw_raw};

    generate
        for (genvar i = 0; i < c_NCH; i++) begin : g_ch
            wam_deb_ch #(
                .DEB_TICKS (DEB_TICKS),
                .CNT_W     (CNT_W),
                .RPT_DLY   (RPT_DLY),
                .RPT_PER   (RPT_PER),
                .RPT_EN    (c_RPT_EN && ((i == c_LFT) || (i == c_RGT)))
            ) u_ch (
                .clk     (clk),
                .rst     (clr),
                .i_raw   (raw_in[i]),
                .o_pulse (ch_pulse[i]),
                .o_level (ch_level[i]),
                .o_busy  (ch_busy[i])
            );
        end
    endgenerate

    always_comb begin
        busy_d = |ch_busy;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Switches export levels only, buttons export pulses only.
    assign unused_ch = ^{ch_pulse[7:0], ch_level[c_PSE:c_LFT]};

    assign lft  = ch_pulse[c_LFT];
    assign rgt  = ch_pulse[c_RGT];
    assign pse  = ch_pulse[c_PSE];
    assign sw   = ch_level[7:0];
    assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_wam_deb.sv
`default_nettype none
// ============================================================================
// Module   : tb_wam_deb
// Brief    : Self-checking bench for wam_deb against a run-length reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_wam_deb;

    localparam int DEB = 4;
    localparam int DLY = 20;
    localparam int PER = 8;
`ifdef WAM_AUTOREPEAT_EN
    localparam bit RPT_ON = 1'b1;
`else
    localparam bit RPT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       btn_lft = 1'b0, btn_rgt = 1'b0, btn_pse = 1'b0;
    logic [7:0] sw_raw = 8'h00;
    logic       lft, rgt, pse, busy;
    logic [7:0] sw;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // Reference model state: 2-cycle input delay, run length of the synced
    // input disagreeing with the accepted level, and hold time for repeats.
    bit  m1 [11];
    bit  m2 [11];
    bit  lvl [11];
    int  run [11];
    int  hold [11];
    bit  exp_pulse [11];
    bit  prev_cnt;
    bit  exp_busy;
    logic [11:0] exp_out;

    wam_deb #(
        .DEB_TICKS (DEB),
        .CNT_W     (4),
        .RPT_DLY   (DLY),
        .RPT_PER   (PER)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .btn_lft (btn_lft),
        .btn_rgt (btn_rgt),
        .btn_pse (btn_pse),
        .sw_raw  (sw_raw),
        .lft     (lft),
        .rgt     (rgt),
        .pse     (pse),
        .sw      (sw),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached (checks %0d/%0d)", n_pass, n_chk);
        $fatal(1, "timeout");
    end

    function automatic logic [11:0] obs();
        return {lft, rgt, pse, sw, busy};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 11; i++) begin
            m1[i] = 0; m2[i] = 0; lvl[i] = 0; run[i] = 0; hold[i] = 0; exp_pulse[i] = 0;
        end
        prev_cnt = 0;
        exp_busy = 0;
        exp_out  = '0;
    endtask

    // Advance one clock and update the model; leaves time at edge+1.
    task automatic step();
        logic [10:0] r;
        logic [7:0]  lv;
        bit          s;
        @(posedge clk);
        r = {btn_pse, btn_rgt, btn_lft, sw_raw};
        #1;
        cyc++;
        exp_busy = prev_cnt;
        prev_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            s = m2[i];
            m2[i] = m1[i];
            m1[i] = r[i];
            exp_pulse[i] = 0;
            if (!lvl[i]) begin
                run[i] = s ? run[i] + 1 : 0;
                if (run[i] == DEB + 1) begin
                    lvl[i] = 1; run[i] = 0; hold[i] = 0; exp_pulse[i] = 1;
                end
            end else if (!s) begin
                run[i] = run[i] + 1;
                if (run[i] == DEB + 1) begin
                    lvl[i] = 0; run[i] = 0;
                end
            end else if (run[i] != 0) begin
                run[i] = 0; hold[i] = 0;
            end else begin
                hold[i] = hold[i] + 1;
                if (RPT_ON && (i == 8 || i == 9) &&
                    (hold[i] == DLY || (hold[i] > DLY && (hold[i] - DLY) % PER == 0)))
                    exp_pulse[i] = 1;
            end
            if (run[i] != 0) prev_cnt = 1;
        end
        for (int i = 0; i < 8; i++) lv[i] = lvl[i];
        exp_out = {exp_pulse[8], exp_pulse[9], exp_pulse[10], lv, exp_busy};
    endtask

    task automatic apply_reset();
        clr = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        btn_lft = 1; btn_rgt = 1; btn_pse = 1; sw_raw = 8'hFF;
        clr = 1'b1;
        model_clear();
        #2;
        n_chk++;
        if (obs() !== 12'h000) $display("FAIL reset_async got=%h exp=000", obs());
        else n_pass++;
        repeat (3) begin
            @(posedge clk); #1;
            n_chk++;
            if (obs() !== 12'h000) $display("FAIL reset_hold got=%h exp=000", obs());
            else n_pass++;
        end
        btn_lft = 0; btn_rgt = 0; btn_pse = 0; sw_raw = 8'h00;
        clr = 1'b0;
        cyc = 0;
    endtask

    task automatic test_lft_hold();
        int pl[$];
        int ex[$];
        apply_reset();
        btn_lft = 1;
        for (int k = 0; k < 50; k++) begin
            step();
            n_chk++;
            if (obs() !== exp_out) $display("FAIL lft_vec cyc=%0d got=%h exp=%h", cyc, obs(), exp_out);
            else n_pass++;
            if (cyc == 5) begin
                n_chk++;
                if (busy !== 1'b1) $display("FAIL lft_busy cyc=5 got=%b exp=1", busy);
                else n_pass++;
            end
            if (lft === 1'b1) pl.push_back(cyc);
        end
        if (RPT_ON) ex = '{7, 27, 35, 43};
        else ex = '{7};
        n_chk++;
        if (pl.size() != ex.size()) $display("FAIL lft_pulse_count got=%0d exp=%0d", pl.size(), ex.size());
        else n_pass++;
        for (int j = 0; j < ex.size() && j < pl.size(); j++) begin
            n_chk++;
            if (pl[j] != ex[j]) $display("FAIL lft_pulse_cyc idx=%0d got=%0d exp=%0d", j, pl[j], ex[j]);
            else n_pass++;
        end
        btn_lft = 0;
        repeat (10) step();
    endtask

    task automatic test_bounce();
        int pl[$];
        btn_rgt = 0;
        apply_reset();
        for (int c = 0; c < 20; c++) begin
            btn_rgt = (c < 2 || c >= 4);
            step();
            n_chk++;
            if (obs() !== exp_out) $display("FAIL bounce_vec cyc=%0d got=%h exp=%h", cyc, obs(), exp_out);
            else n_pass++;
            if (rgt === 1'b1) pl.push_back(cyc);
        end
        n_chk++;
        if (pl.size() != 1 || pl[0] != 11)
            $display("FAIL bounce_pulse got_count=%0d got_first=%0d exp=1@11", pl.size(), (pl.size() > 0) ? pl[0] : -1);
        else n_pass++;
        btn_rgt = 0;
        repeat (10) step();
    endtask

    task automatic test_sw_glitch();
        bit stay_ok = 1;
        sw_raw = 8'h00;
        apply_reset();
        for (int c = 0; c < 24; c++) begin
            sw_raw = (c == 10 || c == 11) ? 8'h00 : 8'hA5;
            step();
            n_chk++;
            if (obs() !== exp_out) $display("FAIL sw_vec cyc=%0d got=%h exp=%h", cyc, obs(), exp_out);
            else n_pass++;
            if (cyc >= 7 && sw !== 8'hA5) stay_ok = 0;
        end
        n_chk++;
        if (!stay_ok || sw !== 8'hA5) $display("FAIL sw_stay got=%h exp=a5", sw);
        else n_pass++;
        sw_raw = 8'h00;
        repeat (10) step();
        n_chk++;
        if (sw !== 8'h00) $display("FAIL sw_release got=%h exp=00", sw);
        else n_pass++;
    endtask

    task automatic test_reset_midcount();
        int pl[$];
        btn_pse = 0;
        apply_reset();
        btn_pse = 1;
        repeat (5) begin
            step();
            n_chk++;
            if (obs() !== exp_out) $display("FAIL mid_vec cyc=%0d got=%h exp=%h", cyc, obs(), exp_out);
            else n_pass++;
        end
        clr = 1'b1;
        model_clear();
        #1;
        n_chk++;
        if (obs() !== 12'h000) $display("FAIL mid_clr got=%h exp=000", obs());
        else n_pass++;
        repeat (2) begin
            @(posedge clk); #1;
            n_chk++;
            if (pse !== 1'b0) $display("FAIL mid_pse_in_clr got=%b exp=0", pse);
            else n_pass++;
        end
        clr = 1'b0;
        cyc = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            n_chk++;
            if (obs() !== exp_out) $display("FAIL mid_after_vec cyc=%0d got=%h exp=%h", cyc, obs(), exp_out);
            else n_pass++;
            if (pse === 1'b1) pl.push_back(cyc);
        end
        n_chk++;
        if (pl.size() != 1 || pl[0] != 7)
            $display("FAIL mid_pse_pulse got_count=%0d got_first=%0d exp=1@7", pl.size(), (pl.size() > 0) ? pl[0] : -1);
        else n_pass++;
        btn_pse = 0;
        repeat (10) step();
    endtask

    task automatic test_simultaneous();
        int hits = 0;
        btn_lft = 0; btn_rgt = 0; btn_pse = 0;
        apply_reset();
        btn_lft = 1; btn_rgt = 1; btn_pse = 1;
        for (int c = 0; c < 12; c++) begin
            step();
            n_chk++;
            if (obs() !== exp_out) $display("FAIL simul_vec cyc=%0d got=%h exp=%h", cyc, obs(), exp_out);
            else n_pass++;
            if (lft === 1'b1 && rgt === 1'b1 && pse === 1'b1 && cyc == 7) hits++;
        end
        n_chk++;
        if (hits != 1) $display("FAIL simul_pulse got=%0d exp=1 joint pulse at cycle 7", hits);
        else n_pass++;
        btn_lft = 0; btn_rgt = 0; btn_pse = 0;
        repeat (10) step();
    endtask

    task automatic test_random();
        int errs = 0;
        logic [10:0] r;
        btn_lft = 0; btn_rgt = 0; btn_pse = 0; sw_raw = 8'h00;
        apply_reset();
        r = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 11; i++)
                if ($urandom_range(5) == 0) r[i] = ~r[i];
            {btn_pse, btn_rgt, btn_lft, sw_raw} = r;
            step();
            n_chk++;
            if (obs() !== exp_out) begin
                if (errs < 10) $display("FAIL random_vec cyc=%0d got=%h exp=%h", cyc, obs(), exp_out);
                errs++;
            end else n_pass++;
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_lft_hold();
        test_bounce();
        test_sw_glitch();
        test_reset_midcount();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
